io_reg_arbiter: RTL and testbench

Round-robin arbiter that shares the 16-bit I/O register file (Config, Status, Led70, IO_A..IO_J data/enable) between several bus masters: the SPI slave, the on-chip I/O sequencer and any later master. It accepts one read or write per grant, issues it to the register file over a single-cycle strobe, waits for the file's acknowledge with a bounded timeout, and returns completion and read data to the granted master. It sits between the masters and the register file. Only one transaction is outstanding at any time.

---
 rtl/io_reg_arbiter.sv | 154 +++++++++++++++
 tb/tb_io_reg_arbiter.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/io_reg_arbiter.sv
// Round-robin arbiter granting one register-file access at a time to N_REQ masters,
// with a bounded acknowledge wait and a sticky timeout flag.
module io_reg_arbiter #(
    parameter int unsigned   N_REQ    = 2,
    parameter int unsigned   AW       = 15,
    parameter int unsigned   DW       = 16,
    parameter int unsigned   TIMEOUT  = 64,
    parameter logic [DW-1:0] ERR_DATA = 16'hDEAD
) (
    input  logic                theClock,
    input  logic                theReset,
    input  logic [N_REQ-1:0]    Req_valid,
    input  logic [N_REQ-1:0]    Req_write,
    input  logic [N_REQ*AW-1:0] Req_addr,
    input  logic [N_REQ*DW-1:0] Req_wdata,
    output logic [N_REQ-1:0]    Req_ready,
    output logic [N_REQ-1:0]    Rsp_valid,
    output logic [DW-1:0]       Rsp_rdata,
    output logic                Reg_en,
    output logic                Reg_we,
    output logic [AW-1:0]       Reg_addr,
    output logic [DW-1:0]       Reg_wdata,
    input  logic [DW-1:0]       Reg_rdata,
    input  logic                Reg_ack,
    input  logic                Err_clear,
    output logic                Err_timeout
);

    localparam int unsigned GW = $clog2(N_REQ);
    localparam int unsigned CW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

    state_e          state_q, state_d;
    logic [GW-1:0]   grant_q, grant_d;
    logic            we_q, we_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic [DW-1:0]   rdata_q, rdata_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            err_q, err_d;
    logic            err_set;

    logic            found;
    logic [GW-1:0]   sel;
    logic [GW:0]     sum;

    // Search starts one past the last grant and wraps, so each master waits at most N_REQ-1 turns.
    always_comb begin
        found = 1'b0;
        sel   = grant_q;
        sum   = '0;
        for (int i = 1; i <= int'(N_REQ); i++) begin
            sum = {1'b0, grant_q} + (GW+1)'(i);
            if (sum >= (GW+1)'(N_REQ)) begin
                sum = sum - (GW+1)'(N_REQ);
            end
            if (!found && Req_valid[sum[GW-1:0]]) begin
                found = 1'b1;
                sel   = sum[GW-1:0];
            end
        end
    end

    always_comb begin
        Req_ready = '0;
        if (state_q == StIdle && found) begin
            Req_ready[sel] = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        cnt_d   = cnt_q;
        err_set = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (found) begin
                    grant_d = sel;
                    we_d    = Req_write[sel];
                    addr_d  = Req_addr[sel*AW +: AW];
                    wdata_d = Req_wdata[sel*DW +: DW];
                    state_d = StIssue;
                end
            end
            StIssue: begin
                cnt_d   = '0;
                state_d = StWait;
            end
            StWait: begin
                // An ack on the final count still wins over the timeout.
                if (Reg_ack) begin
                    rdata_d = we_q ? '0 : Reg_rdata;
                    state_d = StResp;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    rdata_d = we_q ? '0 : ERR_DATA;
                    err_set = 1'b1;
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
        err_d = err_set | (err_q & ~Err_clear);
    end

    always_ff @(posedge theClock or negedge theReset) begin
        if (!theReset) begin
            state_q <= StIdle;
            grant_q <= GW'(N_REQ - 1);
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        Rsp_valid = '0;
        if (state_q == StResp) begin
            Rsp_valid[grant_q] = 1'b1;
        end
    end

    assign Rsp_rdata   = rdata_q;
    assign Reg_en      = (state_q == StIssue);
    assign Reg_we      = we_q;
    assign Reg_addr    = addr_q;
    assign Reg_wdata   = wdata_q;
    assign Err_timeout = err_q;

endmodule

// File: tb/tb_io_reg_arbiter.sv
// Directed bench for io_reg_arbiter: reset, single read, contention, timeout,
// ack/timeout race, mid-wait reset and early-ack rejection.
module tb_io_reg_arbiter;

    localparam int N  = 2;
    localparam int AW = 15;
    localparam int DW = 16;

    logic            clk;
    logic            rst_n;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_write;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    rsp_valid;
    logic [DW-1:0]   rsp_rdata;
    logic            reg_en;
    logic            reg_we;
    logic [AW-1:0]   reg_addr;
    logic [DW-1:0]   reg_wdata;
    logic [DW-1:0]   reg_rdata;
    logic            reg_ack;
    logic            err_clear;
    logic            err_timeout;

    int passed = 0;
    int total  = 0;
    int n;

    io_reg_arbiter dut (
        .theClock    (clk),
        .theReset    (rst_n),
        .Req_valid   (req_valid),
        .Req_write   (req_write),
        .Req_addr    (req_addr),
        .Req_wdata   (req_wdata),
        .Req_ready   (req_ready),
        .Rsp_valid   (rsp_valid),
        .Rsp_rdata   (rsp_rdata),
        .Reg_en      (reg_en),
        .Reg_we      (reg_we),
        .Reg_addr    (reg_addr),
        .Reg_wdata   (reg_wdata),
        .Reg_rdata   (reg_rdata),
        .Reg_ack     (reg_ack),
        .Err_clear   (err_clear),
        .Err_timeout (err_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_write = '0;
        req_addr  = '0;
        req_wdata = '0;
        reg_rdata = '0;
        reg_ack   = 1'b0;
        err_clear = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'h0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_rsp_rdata", 32'(rsp_rdata), 32'h0);
        chk("rst_reg_en", 32'(reg_en), 32'h0);
        chk("rst_reg_we", 32'(reg_we), 32'h0);
        chk("rst_reg_addr", 32'(reg_addr), 32'h0);
        chk("rst_reg_wdata", 32'(reg_wdata), 32'h0);
        chk("rst_err", 32'(err_timeout), 32'h0);
        rst_n = 1'b1;
        tick();

        // Single read by master 0
        req_valid = 2'b01;
        req_write = 2'b00;
        req_addr[0 +: AW] = 15'h02;
        #1;
        chk("rd_ready", 32'(req_ready), 32'h1);
        tick();
        req_valid = '0;
        chk("rd_issue_en", 32'(reg_en), 32'h1);
        chk("rd_issue_addr", 32'(reg_addr), 32'h2);
        chk("rd_issue_we", 32'(reg_we), 32'h0);
        chk("rd_issue_ready", 32'(req_ready), 32'h0);
        tick();
        chk("rd_wait_en", 32'(reg_en), 32'h0);
        reg_ack   = 1'b1;
        reg_rdata = 16'h00A5;
        tick();
        reg_ack = 1'b0;
        chk("rd_rsp_valid", 32'(rsp_valid), 32'h1);
        chk("rd_rsp_rdata", 32'(rsp_rdata), 32'h00A5);
        tick();
        chk("rd_rsp_done", 32'(rsp_valid), 32'h0);

        // Contention from reset: grants alternate 0,1,0,1
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        tick();
        req_valid = 2'b11;
        req_write = 2'b11;
        req_addr  = {15'h0011, 15'h0010};
        req_wdata = {16'h2222, 16'h1111};
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("ct_ready", 32'(req_ready), (k % 2 == 0) ? 32'h1 : 32'h2);
            tick();
            chk("ct_en", 32'(reg_en), 32'h1);
            chk("ct_addr", 32'(reg_addr), (k % 2 == 0) ? 32'h10 : 32'h11);
            chk("ct_wdata", 32'(reg_wdata), (k % 2 == 0) ? 32'h1111 : 32'h2222);
            tick();
            reg_ack   = 1'b1;
            reg_rdata = 16'hFFFF;
            tick();
            reg_ack = 1'b0;
            chk("ct_rsp_valid", 32'(rsp_valid), (k % 2 == 0) ? 32'h1 : 32'h2);
            chk("ct_rsp_rdata", 32'(rsp_rdata), 32'h0);
            tick();
        end
        req_valid = '0;
        req_write = '0;

        // Timeout on read of 15'h29
        req_valid = 2'b01;
        req_addr[0 +: AW] = 15'h29;
        tick();
        req_valid = '0;
        n = 1;
        while (rsp_valid == '0 && n < 200) begin
            tick();
            n++;
        end
        chk("to_latency", 32'(n), 32'd66);
        chk("to_rsp_valid", 32'(rsp_valid), 32'h1);
        chk("to_rdata", 32'(rsp_rdata), 32'hDEAD);
        chk("to_err_set", 32'(err_timeout), 32'h1);
        repeat (3) tick();
        chk("to_err_sticky", 32'(err_timeout), 32'h1);
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        chk("to_err_cleared", 32'(err_timeout), 32'h0);

        // Second timeout with Err_clear in the same cycle as the set
        req_valid = 2'b01;
        tick();
        req_valid = '0;
        for (n = 1; n < 65; n++) tick();
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        chk("to2_rsp_valid", 32'(rsp_valid), 32'h1);
        chk("to2_err_set_wins", 32'(err_timeout), 32'h1);
        tick();
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;

        // Ack arrives in the last WAIT cycle (counter = TIMEOUT-1)
        req_valid = 2'b10;
        req_write = 2'b00;
        req_addr[AW +: AW] = 15'h07;
        tick();
        req_valid = '0;
        for (n = 1; n < 65; n++) tick();
        chk("race_pre_rsp", 32'(rsp_valid), 32'h0);
        reg_ack   = 1'b1;
        reg_rdata = 16'h1234;
        tick();
        reg_ack = 1'b0;
        chk("race_rsp_valid", 32'(rsp_valid), 32'h2);
        chk("race_rdata", 32'(rsp_rdata), 32'h1234);
        chk("race_err", 32'(err_timeout), 32'h0);
        tick();

        // Reset while in WAIT
        req_valid = 2'b01;
        req_write = 2'b01;
        req_addr[0 +: AW]  = 15'h05;
        req_wdata[0 +: DW] = 16'hABCD;
        tick();
        req_valid = '0;
        req_write = '0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk("mr_en", 32'(reg_en), 32'h0);
        chk("mr_we", 32'(reg_we), 32'h0);
        chk("mr_addr", 32'(reg_addr), 32'h0);
        chk("mr_wdata", 32'(reg_wdata), 32'h0);
        chk("mr_rsp_valid", 32'(rsp_valid), 32'h0);
        rst_n     = 1'b1;
        reg_ack   = 1'b1;
        reg_rdata = 16'h9999;
        tick();
        chk("mr_no_rsp1", 32'(rsp_valid), 32'h0);
        tick();
        chk("mr_no_rsp2", 32'(rsp_valid), 32'h0);
        reg_ack = 1'b0;
        req_valid = 2'b10;
        req_addr[AW +: AW] = 15'h03;
        #1;
        chk("mr_m1_ready", 32'(req_ready), 32'h2);
        tick();
        req_valid = '0;
        chk("mr_m1_addr", 32'(reg_addr), 32'h3);
        chk("mr_m1_en", 32'(reg_en), 32'h1);
        tick();
        reg_ack   = 1'b1;
        reg_rdata = 16'h5A5A;
        tick();
        reg_ack = 1'b0;
        chk("mr_m1_rsp", 32'(rsp_valid), 32'h2);
        chk("mr_m1_rdata", 32'(rsp_rdata), 32'h5A5A);
        tick();

        // Ack during ISSUE must be ignored
        req_valid = 2'b01;
        req_addr[0 +: AW] = 15'h11;
        tick();
        req_valid = '0;
        reg_ack   = 1'b1;
        reg_rdata = 16'hBEEF;
        tick();
        reg_ack = 1'b0;
        chk("ea_no_rsp1", 32'(rsp_valid), 32'h0);
        tick();
        chk("ea_no_rsp2", 32'(rsp_valid), 32'h0);
        chk("ea_en_low", 32'(reg_en), 32'h0);
        chk("ea_addr_stable", 32'(reg_addr), 32'h11);
        reg_ack   = 1'b1;
        reg_rdata = 16'h0777;
        tick();
        reg_ack = 1'b0;
        chk("ea_rsp_valid", 32'(rsp_valid), 32'h1);
        chk("ea_rdata", 32'(rsp_rdata), 32'h0777);
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
